tristate_bus_arbiter: RTL



---
 rtl/tristate_bus_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 25 ++
 rtl/tristate_buf.sv | 12 +
 rtl/tristate_bus_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding and a
// width helper used to size index ports.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin scan: first set req bit at or above rr_ptr,
// wrapping modulo N_REQ.
module rr_priority_picker
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             found,
  output logic [IW-1:0]    winner
);

  // Scan from the farthest offset down so the nearest hit to rr_ptr is kept last.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      found  = found | req[(int'(rr_ptr) + k) % N_REQ];
      winner = req[(int'(rr_ptr) + k) % N_REQ] ? IW'((int'(rr_ptr) + k) % N_REQ) : winner;
    end
  end

endmodule

// File: rtl/tristate_buf.sv
// Single tristate driver onto a shared bus; one instance per requester.
module tristate_buf #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] a,
  inout  wire  [W-1:0] y
);

  assign y = en ? a : {W{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with burst limiting
// and a registered turnaround gap between any two owners.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          drive_en,
  output logic [clog2w(N_REQ)-1:0]  owner_id,
  output logic                      bus_idle
);

  localparam int IW = clog2w(N_REQ);
  localparam int BW = clog2w(MAX_BURST + 1);
  localparam int TW = clog2w(TURN_CYCLES + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_MAX  = TW'(TURN_CYCLES);

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [BW-1:0]     burst_cnt;
  logic [TW-1:0]     turn_cnt;
  logic              found;
  logic [IW-1:0]     winner;
  logic [N_REQ-1:0]  win_onehot;
  logic              other_req;
  logic              owner_req;
  logic [IW-1:0]     next_ptr;

  rr_priority_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
  assign other_req  = |(req & ~grant);
  assign owner_req  = req[owner_id];
  assign next_ptr   = (owner_id == IW'(N_REQ - 1)) ? {IW{1'b0}} : owner_id + IW'(1);

  // Arbiter FSM; every output is a register so req never reaches a pin combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= {N_REQ{1'b0}};
      drive_en  <= {N_REQ{1'b0}};
      owner_id  <= {IW{1'b0}};
      bus_idle  <= 1'b1;
      rr_ptr    <= {IW{1'b0}};
      burst_cnt <= {BW{1'b0}};
      turn_cnt  <= {TW{1'b0}};
    end else begin
      case (state)
        IDLE, TURN: begin
          if (state == TURN && turn_cnt < TURN_MAX) begin
            turn_cnt <= turn_cnt + TW'(1);
          end else if (found) begin
            state     <= OWN;
            grant     <= win_onehot;
            drive_en  <= win_onehot;
            owner_id  <= winner;
            bus_idle  <= 1'b0;
            burst_cnt <= BW'(1);
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          // Leave on release, or when the burst budget is spent and someone else waits.
          if (!owner_req || (burst_cnt == BURST_MAX && other_req)) begin
            state    <= TURN;
            grant    <= {N_REQ{1'b0}};
            drive_en <= {N_REQ{1'b0}};
            bus_idle <= 1'b1;
            rr_ptr   <= next_ptr;
            turn_cnt <= TW'(1);
          end else if (burst_cnt < BURST_MAX) begin
            burst_cnt <= burst_cnt + BW'(1);
          end else begin
            burst_cnt <= BURST_MAX;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= {N_REQ{1'b0}};
          drive_en <= {N_REQ{1'b0}};
          bus_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule
